// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states,
// line-level bit constants and parity encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rx_data_sampler.sv
// Mid-bit sampler: three samples around the bit centre,
// majority-voted, with a strobe once the vote is settled.
module rx_data_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_rx,
  input  logic [PRESCALE_W-1:0] i_edge_cnt,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit,
  output logic                  o_valid
);

  logic [2:0]            r_smp;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_s0;
  logic [PRESCALE_W-1:0] w_s2;
  logic [PRESCALE_W-1:0] w_rdy;

  assign w_half = i_prescale >> 1;
  assign w_s0   = w_half - PRESCALE_W'(1);
  assign w_s2   = w_half + PRESCALE_W'(1);
  assign w_rdy  = w_half + PRESCALE_W'(2);

  // capture the line at P/2-1, P/2 and P/2+1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_smp <= '0;
    end else if (i_en) begin
      if (i_edge_cnt == w_s0)   r_smp[0] <= i_rx;
      if (i_edge_cnt == w_half) r_smp[1] <= i_rx;
      if (i_edge_cnt == w_s2)   r_smp[2] <= i_rx;
    end
  end

  assign o_bit = (r_smp[0] & r_smp[1]) |
                 (r_smp[0] & r_smp[2]) |
                 (r_smp[1] & r_smp[2]);

  assign o_valid = i_en && (i_edge_cnt == w_rdy);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled deframer with parity and
// stop checks, one-cycle result pulses per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  logic [PRESCALE_W-1:0] r_edge;
  logic [BW-1:0]         r_bit;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_err;
  logic                  r_stop_err;
  logic                  r_done;

  logic w_busy;
  logic w_last;
  logic w_bit;
  logic w_smp_valid;
  logic w_exp_par;

  assign w_busy    = (r_state != IDLE);
  assign w_last    = (r_edge == r_pre - PRESCALE_W'(1));
  assign w_exp_par = (r_par_typ == PAR_ODD) ?
                     ~^r_shift : ^r_shift;

  rx_data_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_smp (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_en       (w_busy),
    .i_rx       (RX_IN),
    .i_edge_cnt (r_edge),
    .i_prescale (r_pre),
    .o_bit      (w_bit),
    .o_valid    (w_smp_valid)
  );

  // frame FSM, counters, shifter and registered result pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_edge       <= '0;
      r_bit        <= '0;
      r_pre        <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_done       <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;

      if (r_done) begin
        if (!r_par_err && !r_stop_err) begin
          P_DATA     <= r_shift;
          Data_Valid <= 1'b1;
        end
        Parity_Error <= r_par_err;
        Stop_Error   <= r_stop_err;
      end

      if (w_busy)
        r_edge <= w_last ? '0 : r_edge + PRESCALE_W'(1);

      unique case (r_state)
        IDLE: begin
          if (RX_IN == START_BIT) begin
            r_state   <= START;
            r_edge    <= '0;
            r_pre     <= Prescale;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
          end
        end
        START: begin
          if (w_smp_valid && (w_bit != START_BIT)) begin
            r_state <= IDLE;
            r_edge  <= '0;
          end else if (w_last) begin
            r_state    <= DATA;
            r_bit      <= '0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
          end
        end
        DATA: begin
          if (w_smp_valid)
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_last) begin
            if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_state <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_smp_valid)
            r_par_err <= (w_bit != w_exp_par);
          if (w_last)
            r_state <= STOP;
        end
        STOP: begin
          if (w_smp_valid)
            r_stop_err <= (w_bit != STOP_BIT);
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= (RX_IN == START_BIT) ? START : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model
// predicts every result pulse and the held P_DATA.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  typedef struct {
    int         at;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] d;
  } ev_t;

  ev_t        q[$];
  logic [7:0] exp_pdata = 8'h00;
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];

  uart_rx dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                 name, cyc, act, exp);
    end
  endtask

  // every-cycle comparison against the frame model
  always @(negedge CLK) begin
    bit edv, epe, ese;
    edv = 1'b0; epe = 1'b0; ese = 1'b0;
    if (chk_on) begin
      if (q.size() > 0 && q[0].at == cyc) begin
        edv = q[0].dv;
        epe = q[0].pe;
        ese = q[0].se;
        if (q[0].dv) exp_pdata = q[0].d;
        void'(q.pop_front());
      end
      chk("Data_Valid", {31'b0, Data_Valid}, {31'b0, edv});
      chk("Parity_Error", {31'b0, Parity_Error}, {31'b0, epe});
      chk("Stop_Error", {31'b0, Stop_Error}, {31'b0, ese});
      chk("P_DATA", {24'b0, P_DATA}, {24'b0, exp_pdata});
      if (Data_Valid) begin
        dv_cyc.push_back(cyc);
        dv_dat.push_back(P_DATA);
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_neg(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  function automatic logic [5:0] rand_pre();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // drive one frame; rst_bit >= 0 aborts it with a reset
  // pulse in the middle of that data bit
  task automatic send(input logic [7:0] d, input bit pbit,
                      input bit sbit, input bit scramble,
                      input int rst_bit);
    int         p;
    int         n;
    bit         pen, ptyp;
    logic [5:0] sv_pre;
    bit         bits[$];
    ev_t        e;
    p      = int'(Prescale);
    pen    = PAR_EN;
    ptyp   = PAR_TYP;
    sv_pre = Prescale;
    n      = 10 + (pen ? 1 : 0);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(sbit);
    e.at = cyc + n * p + 2;
    e.pe = pen && (pbit != (ptyp ? ~^d : ^d));
    e.se = !sbit;
    e.dv = !e.pe && !e.se;
    e.d  = d;
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      RX_IN = bits[i];
      if (scramble && i == 2) begin
        Prescale = rand_pre();
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
      end
      if (i == n - 1) begin
        Prescale = sv_pre;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
      end
      if (rst_bit >= 0 && i == rst_bit + 1) begin
        repeat (p / 2) @(posedge CLK);
        #1;
        RST = 1'b0;
        q.delete();
        exp_pdata = 8'h00;
        #1;
        chk("rst_P_DATA", {24'b0, P_DATA}, 32'h0);
        chk("rst_Data_Valid", {31'b0, Data_Valid}, 32'h0);
        chk("rst_Parity_Error", {31'b0, Parity_Error}, 32'h0);
        chk("rst_Stop_Error", {31'b0, Stop_Error}, 32'h0);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        return;
      end
      repeat (p) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish",
             cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int gap;
    logic [7:0] d;
    bit pb, sb;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_P_DATA", {24'b0, P_DATA}, 32'h0);
    chk("reset_Data_Valid", {31'b0, Data_Valid}, 32'h0);
    chk("reset_Parity_Error", {31'b0, Parity_Error}, 32'h0);
    chk("reset_Stop_Error", {31'b0, Stop_Error}, 32'h0);
    chk_on = 1'b1;
    RST = 1'b1;
    idle(4);

    // 0xA5, P=8, even parity, pulse 89 cycles after detection
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    s = cyc;
    send(8'hA5, 1'b0, 1'b1, 1'b0, -1);
    wait_neg(s + 89);
    chk("t1_early_dv", {31'b0, Data_Valid}, 32'h0);
    wait_neg(s + 90);
    chk("t1_dv", {31'b0, Data_Valid}, 32'h1);
    chk("t1_data", {24'b0, P_DATA}, 32'hA5);
    chk("t1_perr", {31'b0, Parity_Error}, 32'h0);
    idle(5);

    // same bits, odd parity expected -> parity error
    PAR_TYP = 1'b1;
    s = cyc;
    send(8'hA5, 1'b0, 1'b1, 1'b0, -1);
    wait_neg(s + 90);
    chk("t2_perr", {31'b0, Parity_Error}, 32'h1);
    chk("t2_dv", {31'b0, Data_Valid}, 32'h0);
    chk("t2_data", {24'b0, P_DATA}, 32'hA5);
    idle(5);

    // back-to-back at P=16, no parity
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    dv_cyc.delete(); dv_dat.delete();
    send(8'h3C, 1'b0, 1'b1, 1'b0, -1);
    send(8'hC3, 1'b0, 1'b1, 1'b0, -1);
    idle(40);
    chk("t3_count", dv_cyc.size(), 32'd2);
    if (dv_cyc.size() == 2) begin
      chk("t3_spacing", dv_cyc[1] - dv_cyc[0], 32'd160);
      chk("t3_first", {24'b0, dv_dat[0]}, 32'h3C);
      chk("t3_second", {24'b0, dv_dat[1]}, 32'hC3);
    end

    // 3-cycle glitch, then a real frame
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(16);
    send(8'h81, 1'b0, 1'b1, 1'b0, -1);
    idle(10);
    chk("t4_data", {24'b0, P_DATA}, 32'h81);

    // stop bit low at P=32
    Prescale = 6'd32; PAR_EN = 1'b0;
    s = cyc;
    send(8'h55, 1'b0, 1'b0, 1'b0, -1);
    wait_neg(s + 322);
    chk("t5_serr", {31'b0, Stop_Error}, 32'h1);
    chk("t5_dv", {31'b0, Data_Valid}, 32'h0);
    chk("t5_data", {24'b0, P_DATA}, 32'h81);
    idle(40);

    // reset during data bit 4, then recover
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send(8'hFF, 1'b0, 1'b1, 1'b0, 4);
    idle(10);
    send(8'h12, 1'b0, 1'b1, 1'b0, -1);
    idle(10);
    chk("t6_data", {24'b0, P_DATA}, 32'h12);

    // randomized frames, glitches and mid-frame config noise
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        Prescale = rand_pre();
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        gap = $urandom_range(1, 5);
        idle(gap);
        if ($urandom_range(0, 5) == 0) begin
          RX_IN = 1'b0;
          repeat ($urandom_range(1, int'(Prescale) / 2))
            @(posedge CLK);
          #1;
          idle(int'(Prescale) + 2);
        end
      end
      d  = 8'($urandom);
      pb = PAR_TYP ? ~^d : ^d;
      if ($urandom_range(0, 4) == 0) pb = ~pb;
      sb = ($urandom_range(0, 9) != 0);
      send(d, pb, sb, 1'($urandom), -1);
    end
    idle(50);
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
